// File: rtl/muxn_pipe_arb_if.sv
// Producer/consumer bundle for muxn_pipe_arb: per-channel inputs, select controls, registered output.
// master = producers and consumer side, slave = the selector itself.
interface muxn_pipe_arb_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3
);
  logic                      mode;
  logic [SEL_W-1:0]          select;
  logic [NUM_IN*WIDTH-1:0]   in_data;
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN-1:0]         in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;

  modport master (
    output mode, select, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid, sel_err
  );

  modport slave (
    input  mode, select, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid, sel_err
  );
endinterface

// File: rtl/muxn_pipe_arb.sv
// N-input selector (explicit select or round-robin) feeding one registered output word.
// Latency 1 clk input->output; full throughput; out_ready low holds the word and drops all in_ready.
module muxn_pipe_arb #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  muxn_pipe_arb_if.slave   bus
);
  localparam int             IDX_W    = SEL_W + 1;
  localparam int             NSEL     = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_IN_X = IDX_W'(NUM_IN);

  typedef struct packed {
    logic [SEL_W-1:0] chan;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t             held;
  logic              held_vld;
  logic              err_q;
  logic [SEL_W-1:0]  rr_ptr;

  logic              load_en;
  logic              sel_in_range;
  logic              sel_bad;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt;
  logic [WIDTH-1:0]  gnt_word;
  logic [NUM_IN-1:0] ready_c;
  logic [NSEL-1:0]   vld_ext;

  // Pad valids to the full select range so an out-of-range index reads 0, never X.
  assign vld_ext      = NSEL'(bus.in_valid);
  assign load_en      = !held_vld || bus.out_ready;
  assign sel_in_range = {1'b0, bus.select} < NUM_IN_X;
  assign sel_bad      = !bus.mode && load_en && !sel_in_range;

  always_comb begin : grant_c
    logic [SEL_W:0] idx;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt     = '0;
    if (!bus.mode) begin
      if (sel_in_range && vld_ext[bus.select]) begin
        gnt_vld = 1'b1;
        gnt     = bus.select;
      end
    end else begin
      // Scan from the far end back so the channel closest to rr_ptr wins.
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        idx = {1'b0, rr_ptr} + IDX_W'(k);
        if (idx >= NUM_IN_X) idx = idx - NUM_IN_X;
        if (vld_ext[idx[SEL_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt     = idx[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt_word = '0;
    ready_c  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt == SEL_W'(i)) gnt_word = bus.in_data[i*WIDTH +: WIDTH];
      ready_c[i] = !rst && load_en && gnt_vld && (gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held     <= '0;
      held_vld <= 1'b0;
      err_q    <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      err_q <= sel_bad;
      if (gnt_vld && load_en) begin
        held.data <= gnt_word;
        held.chan <= gnt;
        held_vld  <= 1'b1;
        if (bus.mode)
          rr_ptr <= (gnt == SEL_W'(NUM_IN - 1)) ? '0 : gnt + SEL_W'(1);
      end else if (bus.out_ready) begin
        held_vld <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_data  = held.data;
  assign bus.out_chan  = held.chan;
  assign bus.out_valid = held_vld;
  assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_muxn_pipe_arb.sv
// Directed bench for muxn_pipe_arb: reset, explicit select, bad select, round-robin order,
// backpressure with same-edge drain+load, and reset in the middle of traffic.
module tb_muxn_pipe_arb;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] ch [5];

  muxn_pipe_arb_if #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) bus ();

  muxn_pipe_arb #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ch();
    for (int i = 0; i < 5; i++) bus.in_data[i*32 +: 32] = ch[i];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    int exp_seq [7];
    exp_seq = '{0, 1, 2, 3, 4, 0, 1};

    // Reset held for two clocks with every channel valid
    for (int i = 0; i < 5; i++) ch[i] = 32'h1000_0000 + i;
    load_ch();
    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.select    = 3'd0;
    bus.in_valid  = 5'h1F;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_out_chan",  32'(bus.out_chan), 0);
    chk("rst_sel_err",   32'(bus.sel_err), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 0);

    // Explicit select of channel 2
    rst           = 1'b0;
    ch[2]         = 32'hDEAD_BEEF;
    load_ch();
    bus.select    = 3'd2;
    bus.in_valid  = 5'b00100;
    bus.out_ready = 1'b1;
    #1;
    chk("m0_in_ready_load", 32'(bus.in_ready), 32'b00100);
    tick();
    chk("m0_out_data",  bus.out_data, 32'hDEAD_BEEF);
    chk("m0_out_chan",  32'(bus.out_chan), 2);
    chk("m0_out_valid", 32'(bus.out_valid), 1);
    bus.in_valid = 5'b00000;
    #1;
    chk("m0_in_ready_after", 32'(bus.in_ready), 0);
    tick();
    chk("m0_drain_valid", 32'(bus.out_valid), 0);
    chk("m0_drain_hold",  bus.out_data, 32'hDEAD_BEEF);

    // Out-of-range select
    bus.select   = 3'd6;
    bus.in_valid = 5'h1F;
    #1;
    chk("bad_sel_in_ready", 32'(bus.in_ready), 0);
    tick();
    chk("bad_sel_err",       32'(bus.sel_err), 1);
    chk("bad_sel_out_valid", 32'(bus.out_valid), 0);
    bus.select   = 3'd0;
    bus.in_valid = 5'b00000;
    tick();
    chk("bad_sel_err_clear", 32'(bus.sel_err), 0);

    // Round-robin with every channel valid
    ch[2]        = 32'h1000_0002;
    load_ch();
    bus.mode     = 1'b1;
    bus.in_valid = 5'h1F;
    #1;
    chk("rr_first_ready", 32'(bus.in_ready), 32'b00001);
    for (int n = 0; n < 7; n++) begin
      tick();
      chk($sformatf("rr_chan_%0d", n), 32'(bus.out_chan), 32'(exp_seq[n]));
      chk($sformatf("rr_data_%0d", n), bus.out_data, 32'h1000_0000 + 32'(exp_seq[n]));
    end
    // Pointer now sits at 2; only channel 3 requests
    bus.in_valid = 5'b01000;
    #1;
    chk("rr_lone_ready", 32'(bus.in_ready), 32'b01000);
    tick();
    chk("rr_lone_chan", 32'(bus.out_chan), 3);
    bus.in_valid = 5'h1F;
    #1;
    chk("rr_ptr4_ready", 32'(bus.in_ready), 32'b10000);
    tick();
    chk("rr_ptr4_chan", 32'(bus.out_chan), 4);

    // Backpressure: word from channel 4 must stay put
    bus.out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk($sformatf("bp_in_ready_%0d", n), 32'(bus.in_ready), 0);
      tick();
      chk($sformatf("bp_data_%0d", n),  bus.out_data, 32'h1000_0004);
      chk($sformatf("bp_valid_%0d", n), 32'(bus.out_valid), 1);
    end
    ch[1]         = 32'hCAFE_0001;
    load_ch();
    bus.in_valid  = 5'b00010;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'b00010);
    tick();
    chk("bp_swap_data",  bus.out_data, 32'hCAFE_0001);
    chk("bp_swap_chan",  32'(bus.out_chan), 1);
    chk("bp_swap_valid", 32'(bus.out_valid), 1);

    // Move pointer to 3, then reset with a word held
    bus.in_valid = 5'b00100;
    #1;
    chk("pre_rst_ready", 32'(bus.in_ready), 32'b00100);
    tick();
    chk("pre_rst_chan", 32'(bus.out_chan), 2);
    bus.in_valid  = 5'b00000;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_data",  bus.out_data, 0);
    bus.in_valid  = 5'h1F;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'b00001);
    tick();
    chk("post_rst_chan", 32'(bus.out_chan), 0);
    chk("post_rst_data", bus.out_data, 32'h1000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
